// File: rtl/fetch_stage_if.sv
// fetch_stage_if: handshake, instruction-memory and IF/ID bundle for the fetch stage
interface fetch_stage_if #(parameter int PC_W = 10);
  logic            stall;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_data;
  logic [3:0]      opcode;
  logic [1:0]      CMP_Flag;
  logic [3:0]      rd;
  logic [3:0]      ra;
  logic [3:0]      rb;
  logic [13:0]     imm;
  logic [PC_W-1:0] pc_out;
  logic            id_valid;
  logic [15:0]     fetch_count;
  modport master (
    input  stall, branch_taken, branch_target, imem_data,
    output imem_addr, opcode, CMP_Flag, rd, ra, rb, imm, pc_out, id_valid, fetch_count
  );
  modport slave (
    output stall, branch_taken, branch_target, imem_data,
    input  imem_addr, opcode, CMP_Flag, rd, ra, rb, imm, pc_out, id_valid, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC sequencing over a synchronous instruction memory feeding the IF/ID register
module fetch_stage #(
  parameter int PC_W = 10
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);
  localparam logic [31:0] NOP = 32'hF000_0000;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_fpc;
  logic            r_fvalid;
  logic [31:0]     r_instr;
  logic [PC_W-1:0] r_pc_out;
  logic            r_id_valid;
  logic [15:0]     r_count;
  // a branch redirects at once; a stall re-reads fpc so imem_data stays put
  assign bus.imem_addr   = bus.branch_taken ? bus.branch_target : bus.stall ? r_fpc : r_pc;
  assign bus.opcode      = r_instr[31:28];
  assign bus.CMP_Flag    = r_instr[27:26];
  assign bus.rd          = r_instr[25:22];
  assign bus.ra          = r_instr[21:18];
  assign bus.rb          = r_instr[17:14];
  assign bus.imm         = r_instr[13:0];
  assign bus.pc_out      = r_pc_out;
  assign bus.id_valid    = r_id_valid;
  assign bus.fetch_count = r_count;
  // pc/fpc pipeline and IF/ID: branch squashes with a NOP, stall holds everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= '0;
      r_fpc      <= '0;
      r_fvalid   <= 1'b0;
      r_instr    <= NOP;
      r_pc_out   <= '0;
      r_id_valid <= 1'b0;
      r_count    <= '0;
    end else if (bus.branch_taken) begin
      r_pc       <= bus.branch_target + PC_W'(1);
      r_fpc      <= bus.branch_target;
      r_fvalid   <= 1'b1;
      r_instr    <= NOP;
      r_id_valid <= 1'b0;
    end else if (!bus.stall) begin
      r_pc       <= r_pc + PC_W'(1);
      r_fpc      <= r_pc;
      r_fvalid   <= 1'b1;
      r_instr    <= r_fvalid ? bus.imem_data : NOP;
      r_id_valid <= r_fvalid;
      if (r_fvalid) r_pc_out <= r_fpc;
      if (r_fvalid && r_count != 16'hFFFF) r_count <= r_count + 16'd1;
    end
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter PC_W, 10, program-counter and instruction-memory address width.
REQ-002 Port clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 Port rst  input  1  asynchronous, active-high reset.
REQ-004 Port stall  input  1  hold request from downstream; when high, PC and IF/ID SHALL hold.
REQ-005 Port branch_taken  input  1  branch resolved taken by the downstream stage this cycle.
REQ-006 Port branch_target  input  PC_W  absolute address of the branch destination.
REQ-007 Port imem_addr  output  PC_W  synchronous instruction-memory read address; data returns one cycle later.
REQ-008 Port imem_data  input  32  instruction word for the address presented on the previous edge.
REQ-009 Port opcode  output  4  IF/ID opcode, instr[31:28], feeding the control decoder.
REQ-010 Port CMP_Flag  output  2  IF/ID compare selector, instr[27:26].
REQ-011 Port rd, ra, rb  output  4 each  IF/ID register fields: instr[25:22], [21:18], [17:14].
REQ-012 Port imm  output  14  IF/ID immediate, instr[13:0].
REQ-013 Port pc_out  output  PC_W  address of the instruction held in IF/ID.
REQ-014 Port id_valid  output  1  IF/ID holds a real instruction; low means an injected NOP.
REQ-015 Port fetch_count  output  16  count of valid instructions loaded into IF/ID.

Function
REQ-016 Internal state: pc (next address to issue), fpc (address whose data is on imem_data), fvalid (imem_data is usable), IF/ID register and fetch_count.
REQ-017 imem_addr SHALL equal branch_target when branch_taken=1, else fpc when stall=1, else pc; it is combinational.
REQ-018 Normal cycle (branch_taken=0, stall=0): pc<=pc+1, fpc<=pc, fvalid<=1, IF/ID<=fields of imem_data, pc_out<=fpc, id_valid<=fvalid.
REQ-019 Stall cycle (branch_taken=0, stall=1): pc, fpc, fvalid, IF/ID and fetch_count SHALL hold; re-reading fpc keeps imem_data stable for any stall length.
REQ-020 Branch cycle (branch_taken=1, regardless of stall): pc<=branch_target+1, fpc<=branch_target, fvalid<=1, IF/ID<=NOP; it squashes the wrong-path word on imem_data.
REQ-021 NOP injection SHALL load opcode=4'hF, CMP_Flag=0, rd=ra=rb=0, imm=0 and id_valid=0; pc_out SHALL hold its prior value.
REQ-022 When fvalid=0 in a normal cycle, IF/ID SHALL load the NOP of REQ-021 instead of the fields of imem_data.
REQ-023 Taken-branch penalty SHALL be exactly one bubble; the target instruction SHALL appear in IF/ID on the second edge after branch_taken.
REQ-024 pc and branch_target+1 SHALL wrap modulo 2^PC_W (PC_W=10: 1023+1 -> 0) without a flag.
REQ-025 fetch_count SHALL increment by 1 on each edge that loads id_valid=1, and SHALL saturate at 16'hFFFF.
REQ-026 Branch with simultaneous stall: the branch SHALL take effect and the stall SHALL be ignored for that cycle.

Reset
REQ-027 While rst=1: pc=0, fpc=0, fvalid=0, opcode=4'hF, CMP_Flag=0, rd=ra=rb=0, imm=0, pc_out=0, id_valid=0, fetch_count=0, and imem_addr=0.
REQ-028 Reset asserted mid-stall or mid-branch SHALL discard all in-flight state; the first valid IF/ID after release SHALL be address 0, two edges after release.

Verification
REQ-029 Release reset, mem[i]=i: IF/ID shows NOP for 1 edge, then pc_out=0,1,2,... on consecutive edges; fetch_count=3 after the third valid load.
REQ-030 Assert stall 4 cycles while pc_out=5: imem_addr=6 throughout, pc_out stays 5, and after release pc_out=6 then 7 with no skip or repeat.
REQ-031 Assert branch_taken with branch_target=0x200 while pc_out=10: next edge gives id_valid=0 and opcode=F; following edge gives pc_out=0x200.
REQ-032 Assert branch_taken and stall together with target=0x3FF: the branch is taken, and the sequence runs pc_out=0x3FF then 0x000, wrapping.
REQ-033 Preload fetch_count=0xFFFE by running and then fetch 3 more: the counter reads 0xFFFF and holds.
REQ-034 Pulse rst during a stall with pc=20: all outputs match REQ-027 immediately, and pc_out=0 appears two edges after release.
